// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared types and constants for the frame receive controller
// Contents: state_t (controller states), SYNC_LEN (detector pattern length),
//           DEF_PAYLOAD_BYTES / DEF_HUNT_TIMEOUT (default parameter values).
package frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_HUNT    = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    localparam int SYNC_LEN          = 32;
    localparam int DEF_PAYLOAD_BYTES = 32;
    localparam int DEF_HUNT_TIMEOUT  = 8192;

endpackage

// File: rtl/byte_hold_reg.sv
// rtl/byte_hold_reg.sv - single-entry valid/ready byte holding register with sticky overrun
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_i           drop the held byte (valid and data); wins over load_i
//   clr_ovr_i       clear the sticky overrun flag
//   load_i, data_i  offer a new byte; taken if empty or being accepted, else dropped
//   data_o, valid_o held byte and its valid
//   ready_i         downstream accept
//   overrun_o       sticky, a byte was dropped because the register was full
module byte_hold_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       clr_ovr_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       overrun_o
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       accept;

    assign accept = valid_q & ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (clr_i) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
        end else if (load_i) begin
            // A byte being accepted this cycle frees the slot for the new one.
            if (!valid_q || accept) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// rtl/frame_sync_ctrl.sv - sync-detector sequencer and fixed-length payload byte capture
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en_i             level enable; low returns to IDLE and discards the frame
//   data_i           demodulated bit, bit_valid_i qualifies it for capture
//   det_start_i      sticky sync-found flag from the detector (used in HUNT only)
//   det_rst_o        detector re-arm (high in reset, IDLE and ARM)
//   byte_o/byte_valid_o/byte_ready_i  payload byte stream
//   frame_done_o     pulse with the last payload byte
//   hunt_timeout_o   pulse in the final HUNT cycle before re-arming
//   overrun_o        sticky, a byte was dropped; cleared in ARM
//   busy_o           high outside IDLE
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int HUNT_TIMEOUT  = DEF_HUNT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       data_i,
    input  logic       bit_valid_i,
    input  logic       det_start_i,
    output logic       det_rst_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic       frame_done_o,
    output logic       hunt_timeout_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int            TW        = $clog2(HUNT_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(HUNT_TIMEOUT - 1);
    localparam logic [7:0]    BYTE_LAST = 8'(PAYLOAD_BYTES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    sr_q, sr_d;
    logic          done_q, done_d;
    logic          load, clr_ovr, tmo_hit;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        load    = 1'b0;
        clr_ovr = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                bit_d   = 3'd0;
                byte_d  = 8'd0;
                sr_d    = 8'h00;
                tmo_d   = '0;
                clr_ovr = 1'b1;
                state_d = ST_HUNT;
            end
            ST_HUNT: begin
                // Sync found in the expiring cycle still counts as a sync.
                if (det_start_i) begin
                    tmo_d   = '0;
                    state_d = ST_PAYLOAD;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_ARM;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_PAYLOAD: begin
                if (bit_valid_i) begin
                    sr_d  = {sr_q[6:0], data_i};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        load   = 1'b1;
                        byte_d = byte_q + 8'd1;
                        if (byte_q == BYTE_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_ARM;
                        end
                    end
                end
            end
        endcase
        // Disable overrides everything: abandon the frame silently.
        if (!en_i) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            done_d  = 1'b0;
            clr_ovr = 1'b0;
            tmo_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            sr_q    <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
        end
    end

    byte_hold_reg u_hold (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!en_i),
        .clr_ovr_i (clr_ovr),
        .load_i    (load),
        .data_i    (sr_d),
        .data_o    (byte_o),
        .valid_o   (byte_valid_o),
        .ready_i   (byte_ready_i),
        .overrun_o (overrun_o)
    );

    // rst term keeps the detector in reset before the first clock edge lands.
    assign det_rst_o      = rst | (state_q == ST_IDLE) | (state_q == ST_ARM);
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_done_o   = done_q;
    assign hunt_timeout_o = tmo_hit;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb/tb_frame_sync_ctrl.sv - directed self-checking bench for frame_sync_ctrl
module tb_frame_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic       data_i;
    logic       bit_valid_i;
    logic       det_start_i;
    logic       det_rst_o;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;
    logic       frame_done_o;
    logic       hunt_timeout_o;
    logic       overrun_o;
    logic       busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    frame_sync_ctrl #(
        .PAYLOAD_BYTES (2),
        .HUNT_TIMEOUT  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .data_i         (data_i),
        .bit_valid_i    (bit_valid_i),
        .det_start_i    (det_start_i),
        .det_rst_o      (det_rst_o),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .frame_done_o   (frame_done_o),
        .hunt_timeout_o (hunt_timeout_o),
        .overrun_o      (overrun_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int gap);
        for (int i = 7; i > 7 - nbits; i--) begin
            data_i      = b[i];
            bit_valid_i = 1'b1;
            tick();
            bit_valid_i = 1'b0;
            if (i > 8 - nbits) begin
                for (int g = 0; g < gap; g++) begin
                    data_i = ~b[i];
                    tick();
                end
            end
        end
    endtask

    task automatic sync();
        det_start_i = 1'b1;
        tick();
        det_start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; data_i = 1'b0; bit_valid_i = 1'b0;
        det_start_i = 1'b0; byte_ready_i = 1'b1;

        // 1. reset, idle, arm, hunt
        tick(); tick(); tick();
        chk("rst_det_rst", det_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", byte_valid_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_ovr", overrun_o, 0);
        rst = 1'b0;
        tick();
        chk("idle_det_rst", det_rst_o, 1);
        chk("idle_busy", busy_o, 0);
        en_i = 1'b1;
        tick();
        chk("arm_det_rst", det_rst_o, 1);
        chk("arm_busy", busy_o, 1);
        tick();
        chk("hunt_det_rst", det_rst_o, 0);
        chk("hunt_busy", busy_o, 1);

        // 2. sync then two bytes with ready high
        sync();
        send_bits(8'hA5, 8, 0);
        chk("b0_valid", byte_valid_o, 1);
        chk("b0_data", byte_o, 8'hA5);
        chk("b0_done", frame_done_o, 0);
        send_bits(8'h3C, 8, 0);
        chk("b1_valid", byte_valid_o, 1);
        chk("b1_data", byte_o, 8'h3C);
        chk("b1_done", frame_done_o, 1);
        chk("b1_arm", det_rst_o, 1);
        tick();
        chk("post_valid", byte_valid_o, 0);
        chk("post_done", frame_done_o, 0);
        chk("post_hunt", det_rst_o, 0);

        // 3. two timeout periods of 17 cycles
        for (int p = 0; p < 2; p++) begin
            for (int c = 1; c < 16; c++) begin
                chk("tmo_early", hunt_timeout_o, 0);
                tick();
            end
            chk("tmo_pulse", hunt_timeout_o, 1);
            chk("tmo_det_rst", det_rst_o, 0);
            tick();
            chk("tmo_arm", det_rst_o, 1);
            chk("tmo_arm_pulse", hunt_timeout_o, 0);
            tick();
            chk("tmo_rehunt", det_rst_o, 0);
        end

        // 4. ready low: hold 0x11, drop 0x22 and 0x33
        byte_ready_i = 1'b0;
        sync();
        send_bits(8'h11, 8, 0);
        chk("h11_data", byte_o, 8'h11);
        chk("h11_valid", byte_valid_o, 1);
        chk("h11_ovr", overrun_o, 0);
        send_bits(8'h22, 8, 0);
        chk("h22_data", byte_o, 8'h11);
        chk("h22_ovr", overrun_o, 1);
        chk("h22_done", frame_done_o, 1);
        tick();
        chk("h_arm_ovr_clr", overrun_o, 0);
        chk("h_hold_survive", byte_o, 8'h11);
        chk("h_hold_valid", byte_valid_o, 1);
        sync();
        send_bits(8'h33, 8, 0);
        chk("h33_data", byte_o, 8'h11);
        chk("h33_ovr", overrun_o, 1);
        chk("h33_done", frame_done_o, 0);

        // 5. drain, then gapped second byte of the frame
        byte_ready_i = 1'b1;
        tick();
        chk("drain_valid", byte_valid_o, 0);
        chk("drain_ovr", overrun_o, 1);
        send_bits(8'h5A, 8, 2);
        chk("gap_data", byte_o, 8'h5A);
        chk("gap_valid", byte_valid_o, 1);
        chk("gap_done", frame_done_o, 1);
        tick();
        chk("gap_ovr_clr", overrun_o, 0);
        chk("gap_valid_clr", byte_valid_o, 0);

        // 6. disable after 13 payload bits, then clean restart
        sync();
        byte_ready_i = 1'b0;
        send_bits(8'hC3, 8, 0);
        chk("c3_data", byte_o, 8'hC3);
        chk("c3_done", frame_done_o, 0);
        send_bits(8'h96, 5, 0);
        en_i = 1'b0;
        tick();
        chk("dis_busy", busy_o, 0);
        chk("dis_det_rst", det_rst_o, 1);
        chk("dis_valid", byte_valid_o, 0);
        chk("dis_done", frame_done_o, 0);
        tick();
        chk("dis_done2", frame_done_o, 0);
        en_i = 1'b1;
        byte_ready_i = 1'b1;
        tick();
        chk("re_arm", det_rst_o, 1);
        tick();
        chk("re_hunt", det_rst_o, 0);
        sync();
        send_bits(8'hE7, 8, 0);
        chk("re_data", byte_o, 8'hE7);
        chk("re_valid", byte_valid_o, 1);
        chk("re_done", frame_done_o, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
Frame receive controller for the Merge_Data path. It sequences the 32-bit sync-pattern detector: it re-arms the detector, waits for its sticky start flag and bounds the hunt with a timeout. After sync it captures a fixed-length payload from the same demodulated bitstream, MSB-first, into bytes. Bytes leave on a valid/ready interface, and the block reports frame completion, timeouts and overruns.

Parameters:
PAYLOAD_BYTES, 32, payload bytes captured per frame after sync (1..255)
HUNT_TIMEOUT, 8192, clk cycles allowed in HUNT before giving up and re-arming (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en_i  in  1  level enable; 0 forces return to IDLE at next edge
data_i  in  1  demodulated bit (same signal feeding the detector)
bit_valid_i  in  1  data_i qualifier for payload capture
det_start_i  in  1  sticky sync-found flag from detector
det_rst_o  out  1  detector re-arm pulse (drives detector rst)
byte_o  out  8  assembled payload byte
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  downstream accept
frame_done_o  out  1  1-cycle pulse, last payload byte captured
hunt_timeout_o  out  1  1-cycle pulse, HUNT expired
overrun_o  out  1  sticky, byte lost because holding register full
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except det_rst_o=1. The detector is held in reset while the controller is in reset. State=IDLE, counters=0.
- IDLE: det_rst_o=1. If en_i=1, go to ARM.
- ARM (1 cycle): det_rst_o=1. Clear the bit counter, byte counter, shift register and overrun_o. Next state is HUNT.
- HUNT: det_rst_o=0. The timeout counter increments every cycle.
  - If det_start_i=1, go to PAYLOAD and clear the timeout counter.
  - Else if the counter reaches HUNT_TIMEOUT-1, pulse hunt_timeout_o and go to ARM.
  - If det_start_i and the timeout occur in the same cycle, det_start_i wins and no timeout pulse is issued.
- PAYLOAD: the first captured bit is the first bit_valid_i=1 cycle strictly after the cycle in which the FSM entered PAYLOAD.
  - Each valid bit shifts into the shift register, MSB first: sr <= {sr[6:0], data_i}.
  - After the 8th bit, the completed byte is presented in the same edge: if the holding register is empty, or is being accepted this cycle (byte_valid_o & byte_ready_i), load byte_o and set byte_valid_o.
  - Otherwise drop the new byte and set overrun_o.
  - The byte counter increments either way.
  - When the byte counter reaches PAYLOAD_BYTES, pulse frame_done_o (same edge as the last byte load or drop) and go to ARM. The next frame hunt starts automatically.
- Output handshake: byte_valid_o stays high until byte_ready_i=1. byte_o is stable while valid and not accepted. The holding register survives the ARM/HUNT transitions; it is cleared only by rst or the IDLE entry.
- en_i=0 in any state: go to IDLE next edge, assert det_rst_o, clear byte_valid_o, and discard any partial byte or frame. No frame_done_o is issued.
- rst mid-frame: immediate return to reset values at the next edge, regardless of state.
- The timeout counter width is $clog2(HUNT_TIMEOUT). The byte counter width is 8. The bit counter is 3 bits and wraps naturally.
- det_start_i is ignored outside HUNT.

Decomposition:
- Shared package frame_sync_pkg contains:
  - the state enum (IDLE, ARM, HUNT, PAYLOAD)
  - SYNC_LEN=32
  - the default PAYLOAD_BYTES and HUNT_TIMEOUT values
- One natural sub-module is byte_hold_reg: the single-entry valid/ready holding register with an overrun output. It is reusable elsewhere in Merge_Data.
- The FSM, shift register and counters stay in the top module.

Test Plan:
1. rst held 3 cycles, then released with en_i=0 → det_rst_o=1, busy_o=0, byte_valid_o=0. Then en_i=1 → one ARM cycle, then HUNT with det_rst_o=0.
2. det_start_i raised in HUNT, then 16 valid bits 0xA5,0x3C with byte_ready_i=1 and PAYLOAD_BYTES=2 → byte_o=0xA5 then 0x3C, each with valid for 1 cycle; frame_done_o pulses with the 2nd byte; FSM returns to ARM.
3. HUNT_TIMEOUT=16 and det_start_i never rises → hunt_timeout_o pulses on the 16th HUNT cycle, followed by a det_rst_o pulse (ARM). The cycle repeats every 17 cycles.
4. byte_ready_i=0 throughout, 3 bytes sent (0x11,0x22,0x33) → byte_o holds 0x11; overrun_o rises when 0x22 completes; 0x33 is also dropped; overrun_o stays high until the next ARM.
5. Bits sent with gaps (bit_valid_i toggling 1,0,0,1,...) → bytes assemble correctly. Cycles with bit_valid_i=0 do not shift.
6. en_i dropped after 13 payload bits → IDLE next edge, byte_valid_o=0, det_rst_o=1, no frame_done_o. A re-enable starts a clean hunt, and the first byte after the next sync is correct.
